serial_chunk_adder: RTL and testbench

//   Multi-cycle add/subtract unit. Processes WIDTH-bit operands CHUNK bits per clock through a

---
 rtl/serial_chunk_adder_pkg.sv | 10 +
 rtl/serial_chunk_adder_chunk.sv | 27 ++
 rtl/serial_chunk_adder.sv | 117 +++++++++++
 tb/tb_serial_chunk_adder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// Shared FSM state type for the serial chunk adder.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_chunk_adder_chunk.sv
// Combinational ripple of CHUNK full-adder cells; also exposes the carry into the top cell.
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[CHUNK];
    cmsb = c[CHUNK-1];
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock through one chunk_adder, carry held in a flop.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $fatal(1, "serial_chunk_adder: CHUNK must divide WIDTH");
    end
  endgenerate

  state_t            state, state_n;
  logic [WIDTH-1:0]  a_sh, b_sh, a_next;
  logic              cy;
  logic [CW-1:0]     count;
  logic              accept, last;
  logic [CHUNK-1:0]  csum;
  logic              ccout, ccmsb;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (cy),
    .s    (csum),
    .cout (ccout),
    .cmsb (ccmsb)
  );

  // A_sh doubles as the result register: sum chunks enter at the MSB as operand chunks leave the LSB.
  generate
    if (CHUNK == WIDTH) begin : g_full
      assign a_next = csum;
    end else begin : g_part
      assign a_next = {csum, a_sh[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        last = (count == CW'(NCHUNK - 1));
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      cy        <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        cy    <= sub;
        count <= '0;
      end else if (state == S_RUN) begin
        a_sh  <= a_next;
        b_sh  <= b_sh >> CHUNK;
        cy    <= ccout;
        count <= count + 1'b1;
        if (last) begin
          sum       <= a_next;
          carry_out <= ccout;
          overflow  <= ccmsb ^ ccout;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder: vector table + scoreboard on the C1 instance, latency on C4/C8.
module tb_serial_chunk_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
  logic       busy1, done1, co1, ov1;
  logic       busy4, done4, co4, ov4;
  logic       busy8, done8, co8, ov8;
  logic [7:0] sum1, sum4, sum8;

  int checks = 0;
  int passes = 0;

  logic [9:0] sb_q[$];

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       co;
    logic       ov;
  } vec_t;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .reset(rst), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .reset(rst), .start(start4), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4), .overflow(ov4));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(rst), .start(start8), .sub(sub), .a(a), .b(b),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passes++;
  endtask

  function automatic logic [9:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] yy;
    logic [8:0] r;
    logic       ov;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {8'd0, s};
    ov = (x[7] == yy[7]) && (r[7] != x[7]);
    return {r[7:0], r[8], ov};
  endfunction

  // Scoreboard: every done pulse from the C1 instance must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (sb_q.size() == 0) chk("spurious_done", 32'(done1), 32'd0);
      else chk("result", {22'd0, sum1, co1, ov1}, {22'd0, sb_q.pop_front()});
    end
  end

  task automatic run1(input logic s, input logic [7:0] x, input logic [7:0] y,
                      input logic [9:0] e, output int lat);
    @(negedge clk);
    sub = s; a = x; b = y; start1 = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (done1) break;
    end
  endtask

  task automatic wait_done(input int which, output int lat);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if ((which == 4 && done4) || (which == 8 && done8)) break;
    end
  endtask

  initial begin
    vec_t vt[8];
    int   lat;
    logic [7:0] ra, rb;
    logic       rs;

    vt[0] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
    vt[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{1'b1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0};
    vt[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vt[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};

    #12;
    chk("reset_outputs", {21'd0, sum1, co1, ov1, busy1, done1}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run1(vt[i].sub, vt[i].a, vt[i].b, {vt[i].sum, vt[i].co, vt[i].ov}, lat);
      chk("latency_c1", 32'(lat), 32'd8);
    end

    // start held through RUN with wandering operands, then re-accepted in the DONE cycle
    @(negedge clk);
    sub = 1'b0; a = 8'h10; b = 8'h20; start1 = 1'b1;
    sb_q.push_back({8'h30, 1'b0, 1'b0});
    @(posedge clk);
    #1 chk("busy_in_run", 32'(busy1), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1) break;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    end
    sub = 1'b0; a = 8'h03; b = 8'h04;
    sb_q.push_back({8'h07, 1'b0, 1'b0});
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (done1) break;
    end
    chk("latency_back_to_back", 32'(lat), 32'd8);

    // asynchronous reset three chunks into an operation
    @(negedge clk);
    sub = 1'b0; a = 8'hAA; b = 8'h11; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_mid_run", {21'd0, sum1, co1, ov1, busy1, done1}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (12) @(negedge clk);
    run1(1'b0, 8'h01, 8'h01, {8'h02, 1'b0, 1'b0}, lat);
    chk("latency_after_reset", 32'(lat), 32'd8);

    // CHUNK = 4 and CHUNK = WIDTH
    @(negedge clk);
    sub = 1'b0; a = 8'h7F; b = 8'h01; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    wait_done(4, lat);
    chk("latency_c4", 32'(lat), 32'd2);
    chk("result_c4", {22'd0, sum4, co4, ov4}, {22'd0, 8'h80, 1'b0, 1'b1});

    @(negedge clk);
    sub = 1'b1; a = 8'h80; b = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done(8, lat);
    chk("latency_c8", 32'(lat), 32'd1);
    chk("result_c8", {22'd0, sum8, co8, ov8}, {22'd0, 8'h7F, 1'b1, 1'b1});

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run1(rs, ra, rb, model(rs, ra, rb), lat);
      if (lat != 8) chk("latency_random", 32'(lat), 32'd8);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
